// File: rtl/bcd_time_counter.sv
// bcd_time_counter: time-of-day clock in BCD hours/minutes/seconds.
// A prescaler divides the system clock down to a 1 Hz advance.
// Hours are always held in 24-hour BCD. 12-hour display is a pure output mapping.
// Optional alarm comparator: define BCD_TIME_ALARM_EN.
module bcd_time_counter #(
    parameter int CLK_FREQ = 100000000,
    parameter int PRESC_W  = 27
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Mode12,
    input  logic       Load,
    input  logic [7:0] LoadHours,
    input  logic [7:0] LoadMinutes,
    input  logic       IncMin,
    input  logic       IncHour,
`ifdef BCD_TIME_ALARM_EN
    input  logic       AlarmSet,
    input  logic [7:0] AlarmHours,
    input  logic [7:0] AlarmMinutes,
    input  logic       AlarmArm,
    output logic       AlarmHit,
`endif
    output logic [3:0] hoursTens,
    output logic [3:0] hoursUnits,
    output logic [3:0] minutesTens,
    output logic [3:0] minutesUnits,
    output logic [3:0] secondsTens,
    output logic [3:0] secondsUnits,
    output logic       PM,
    output logic       SecondTick,
    output logic       LoadErr
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ - 1);

    // A preset is usable only if every digit is decimal and the value is a real time of day.
    function automatic logic time_valid(input logic [7:0] hrs, input logic [7:0] mins);
        logic digits_ok;
        logic range_ok;
        digits_ok = (hrs[3:0] <= 4'd9) && (hrs[7:4] <= 4'd9) &&
                    (mins[3:0] <= 4'd9) && (mins[7:4] <= 4'd9);
        range_ok  = (hrs[7:4] < 4'd2 || (hrs[7:4] == 4'd2 && hrs[3:0] <= 4'd3)) &&
                    (mins[7:4] <= 4'd5);
        return digits_ok && range_ok;
    endfunction

    // Two-digit BCD increment that wraps to 00 after reaching the given limit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        if (value == limit) begin
            return 8'h00;
        end else if (value[3:0] == 4'd9) begin
            return {value[7:4] + 4'd1, 4'd0};
        end else begin
            return {value[7:4], value[3:0] + 4'd1};
        end
    endfunction

    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [7:0]         hours_reg, hours_next;
    logic [7:0]         minutes_reg, minutes_next;
    logic [7:0]         seconds_reg, seconds_next;
    logic               tick_reg, tick_next;
    logic               load_err_reg, load_err_next;
    logic               tick_due;
    logic               load_ok;
    logic               load_rejected;
    logic               alarm_rejected;

    assign tick_due = Enable && (presc_reg == PRESC_MAX);
    assign load_ok  = time_valid(LoadHours, LoadMinutes);

    // Next-state: Load beats the increment strobes, which beat the 1 Hz tick.
    always_comb begin
        presc_next    = presc_reg;
        hours_next    = hours_reg;
        minutes_next  = minutes_reg;
        seconds_next  = seconds_reg;
        tick_next     = 1'b0;
        load_rejected = 1'b0;
        if (Load) begin
            // A rejected load leaves every register alone, including the prescaler.
            if (load_ok) begin
                hours_next   = LoadHours;
                minutes_next = LoadMinutes;
                seconds_next = 8'h00;
                presc_next   = '0;
            end else begin
                load_rejected = 1'b1;
            end
        end else begin
            if (Enable) begin
                presc_next = tick_due ? '0 : presc_reg + PRESC_W'(1);
            end
            if (IncMin || IncHour) begin
                // Manual stepping never carries, and it swallows a coincident tick.
                if (IncMin) begin
                    minutes_next = bcd_inc(minutes_reg, 8'h59);
                end
                if (IncHour) begin
                    hours_next = bcd_inc(hours_reg, 8'h23);
                end
            end else if (tick_due) begin
                tick_next    = 1'b1;
                seconds_next = bcd_inc(seconds_reg, 8'h59);
                if (seconds_reg == 8'h59) begin
                    minutes_next = bcd_inc(minutes_reg, 8'h59);
                    if (minutes_reg == 8'h59) begin
                        hours_next = bcd_inc(hours_reg, 8'h23);
                    end
                end
            end
        end
    end

    assign load_err_next = load_rejected | alarm_rejected;

    // Time, prescaler and status pulse registers.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            presc_reg    <= '0;
            hours_reg    <= 8'h00;
            minutes_reg  <= 8'h00;
            seconds_reg  <= 8'h00;
            tick_reg     <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            hours_reg    <= hours_next;
            minutes_reg  <= minutes_next;
            seconds_reg  <= seconds_next;
            tick_reg     <= tick_next;
            load_err_reg <= load_err_next;
        end
    end

`ifdef BCD_TIME_ALARM_EN
    logic [7:0] alarm_hours_reg, alarm_hours_next;
    logic [7:0] alarm_minutes_reg, alarm_minutes_next;
    logic       alarm_hit_reg, alarm_hit_next;
    logic       time_changes;

    assign time_changes = {hours_next, minutes_next, seconds_next} !=
                          {hours_reg, minutes_reg, seconds_reg};

    // Alarm preset capture and sticky hit flag; the hit fires as the time enters HH:MM:00.
    always_comb begin
        alarm_hours_next   = alarm_hours_reg;
        alarm_minutes_next = alarm_minutes_reg;
        alarm_rejected     = 1'b0;
        alarm_hit_next     = 1'b0;
        if (AlarmSet) begin
            if (time_valid(AlarmHours, AlarmMinutes)) begin
                alarm_hours_next   = AlarmHours;
                alarm_minutes_next = AlarmMinutes;
            end else begin
                alarm_rejected = 1'b1;
            end
        end
        if (AlarmArm) begin
            alarm_hit_next = alarm_hit_reg ||
                             (time_changes && seconds_next == 8'h00 &&
                              hours_next == alarm_hours_reg &&
                              minutes_next == alarm_minutes_reg);
        end
    end

    // Alarm registers.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            alarm_hours_reg   <= 8'h00;
            alarm_minutes_reg <= 8'h00;
            alarm_hit_reg     <= 1'b0;
        end else begin
            alarm_hours_reg   <= alarm_hours_next;
            alarm_minutes_reg <= alarm_minutes_next;
            alarm_hit_reg     <= alarm_hit_next;
        end
    end

    assign AlarmHit = alarm_hit_reg;
`else
    assign alarm_rejected = 1'b0;
`endif

    logic [4:0] hour_bin;
    logic [4:0] hour_disp;

    // Display hours: binary detour keeps the 12-hour fold simple; reacts to Mode12 immediately.
    always_comb begin
        hour_bin  = 5'(hours_reg[7:4]) * 5'd10 + 5'(hours_reg[3:0]);
        hour_disp = hour_bin;
        if (Mode12) begin
            if (hour_bin == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_bin > 5'd12) begin
                hour_disp = hour_bin - 5'd12;
            end
        end
        if (hour_disp >= 5'd20) begin
            hoursTens  = 4'd2;
            hoursUnits = 4'(hour_disp - 5'd20);
        end else if (hour_disp >= 5'd10) begin
            hoursTens  = 4'd1;
            hoursUnits = 4'(hour_disp - 5'd10);
        end else begin
            hoursTens  = 4'd0;
            hoursUnits = 4'(hour_disp);
        end
    end

    assign PM           = (hour_bin >= 5'd12);
    assign minutesTens  = minutes_reg[7:4];
    assign minutesUnits = minutes_reg[3:0];
    assign secondsTens  = seconds_reg[7:4];
    assign secondsUnits = seconds_reg[3:0];
    assign SecondTick   = tick_reg;
    assign LoadErr      = load_err_reg;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter (alarm option off): directed scenarios plus a random
// phase, all compared against a seconds-of-day reference model.
module tb_bcd_time_counter;

    localparam int CF = 10;

    logic        clk = 1'b0;
    logic        rst, en, m12, ld, im, ih;
    logic [7:0]  lh, lm;
    logic [3:0]  ht, hu, mt, mu, st, su;
    logic        pm, tick, err;
    logic [23:0] tm;

    int checks = 0;
    int errors = 0;

    // Reference state: time as seconds since midnight, prescaler as a plain count.
    int tod, pc, exp_tick, exp_err;

    assign tm = {ht, hu, mt, mu, st, su};

    bcd_time_counter #(.CLK_FREQ(CF), .PRESC_W(4)) dut (
        .Clk_100M     (clk),
        .Reset        (rst),
        .Enable       (en),
        .Mode12       (m12),
        .Load         (ld),
        .LoadHours    (lh),
        .LoadMinutes  (lm),
        .IncMin       (im),
        .IncHour      (ih),
        .hoursTens    (ht),
        .hoursUnits   (hu),
        .minutesTens  (mt),
        .minutesUnits (mu),
        .secondsTens  (st),
        .secondsUnits (su),
        .PM           (pm),
        .SecondTick   (tick),
        .LoadErr      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int to_bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int bcd_val(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit load_valid(input logic [7:0] h, input logic [7:0] m);
        if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || m[7:4] > 4'd9 || m[3:0] > 4'd9) return 1'b0;
        return (bcd_val(h) <= 23) && (bcd_val(m) <= 59);
    endfunction

    task automatic model_reset();
        tod = 0; pc = 0; exp_tick = 0; exp_err = 0;
    endtask

    task automatic model_step();
        int h, m, s;
        bit due;
        exp_tick = 0;
        exp_err  = 0;
        if (ld) begin
            if (load_valid(lh, lm)) begin
                tod = bcd_val(lh) * 3600 + bcd_val(lm) * 60;
                pc  = 0;
            end else begin
                exp_err = 1;
            end
        end else begin
            due = en && (pc == CF - 1);
            if (en) pc = (pc + 1) % CF;
            if (im || ih) begin
                h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
                if (im) m = (m + 1) % 60;
                if (ih) h = (h + 1) % 24;
                tod = h * 3600 + m * 60 + s;
            end else if (due) begin
                tod = (tod + 1) % 86400;
                exp_tick = 1;
            end
        end
    endtask

    task automatic compare_all();
        int h, dh;
        h  = tod / 3600;
        dh = m12 ? ((h + 11) % 12) + 1 : h;
        check("hours",   int'({ht, hu}), to_bcd(dh));
        check("minutes", int'({mt, mu}), to_bcd((tod / 60) % 60));
        check("seconds", int'({st, su}), to_bcd(tod % 60));
        check("pm",      int'(pm),       (h >= 12) ? 1 : 0);
        check("tick",    int'(tick),     exp_tick);
        check("loaderr", int'(err),      exp_err);
    endtask

    // One clock: drive inputs, let the edge happen, step the model, compare 1 ns later.
    task automatic cycle(input bit l, input logic [7:0] h, input logic [7:0] m,
                         input bit i_m, input bit i_h);
        ld = l; lh = h; lm = m; im = i_m; ih = i_h;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (l || i_m || i_h)
            $display("txn load=%0b %02h:%02h incmin=%0b inchour=%0b -> %h%h:%h%h:%h%h err=%0b",
                     l, h, m, i_m, i_h, ht, hu, mt, mu, st, su, err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; m12 = 1'b0;
        ld = 1'b0; lh = 8'h00; lm = 8'h00; im = 1'b0; ih = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        m12 = 1'b1;
        #1;
        compare_all();
        check("rst_h12", int'({ht, hu}), 'h12);
        m12 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Free run from reset: first second after 10 edges, one minute after 600.
        en = 1'b1;
        idle(10);
        check("first_sec", int'(su), 1);
        idle(590);
        check("t600", int'(tm), 'h000100);

        // Midnight rollover in 12-hour display.
        m12 = 1'b1;
        cycle(1'b1, 8'h23, 8'h59, 1'b0, 1'b0);
        check("h12_11pm", int'({ht, hu}), 'h11);
        idle(600);
        check("midnight", int'(tm), 'h120000);
        m12 = 1'b0;
        #1;
        check("midnight24", int'(tm), 'h000000);

        // Rejected presets.
        cycle(1'b1, 8'h24, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 8'h5A, 1'b0, 1'b0);
        cycle(1'b1, 8'h1A, 8'h00, 1'b0, 1'b0);
        idle(1);

        // Manual stepping without carry.
        cycle(1'b1, 8'h10, 8'h59, 1'b0, 1'b0);
        idle(300);
        check("pre_incmin", int'(tm), 'h105930);
        cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check("incmin_wrap", int'(tm), 'h100030);
        cycle(1'b1, 8'h23, 8'h15, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("inchour_wrap", int'(tm), 'h001500);

        // Tick, Load and IncMin in the same cycle: the load wins outright.
        cycle(1'b1, 8'h05, 8'h30, 1'b0, 1'b0);
        idle(9);
        cycle(1'b1, 8'h07, 8'h45, 1'b1, 1'b0);
        check("load_wins", int'(tm), 'h074500);
        check("load_no_tick", int'(tick), 0);

        // Freeze mid-count, then resume for the remaining prescaler cycles.
        idle(4);
        en = 1'b0;
        idle(25);
        en = 1'b1;
        idle(5);
        check("resume_wait", int'(tick), 0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("resume_tick", int'(tick), 1);
        check("resume_time", int'(tm), 'h074501);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit l, a, b;
            logic [7:0] h, m;
            if ($urandom_range(0, 49) == 0) en = ~en;
            m12 = 1'($urandom_range(0, 1));
            l = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 19) == 0);
            b = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) begin
                h = 8'(to_bcd(int'($urandom_range(0, 23))));
                m = 8'(to_bcd(int'($urandom_range(0, 59))));
            end else begin
                h = 8'($urandom_range(0, 255));
                m = 8'($urandom_range(0, 255));
            end
            cycle(l, h, m, a, b);
        end

        // Asynchronous reset in the middle of a second at 12:34:56.
        en = 1'b1; m12 = 1'b0;
        cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        idle(560);
        check("pre_reset", int'(tm), 'h123456);
        idle(3);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst", int'(tm), 'h000000);
        compare_all();
        #1 rst = 1'b0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
